// File: rtl/pcm_bus_engine.sv
// pcm_bus_engine: timed PCM read/write bus cycles with an optional PCM reset/recovery sequence.
// Macro PCM_RESET_SEQ_EN enables the INIT_RST/INIT_REC power-up sequence.
module pcm_bus_engine #(
  parameter int WR_CYC  = 6,
  parameter int RD_CYC  = 13,
  parameter int RST_CYC = 16,
  parameter int REC_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [22:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        wr_done,
  output logic [22:0] addr,
  inout  wire  [15:0] data,
  output logic        pcm_rst_n,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n
);
  typedef enum logic [2:0] {INIT_RST, INIT_REC, IDLE, WR_STB, WR_REC, RD_STB, RD_REC} state_t;
  localparam logic [7:0] RST_CNT = 8'(RST_CYC - 1);
`ifdef PCM_RESET_SEQ_EN
  localparam state_t RST_ST = INIT_RST;
`else
  localparam state_t RST_ST = IDLE;
`endif
  state_t      r_state, w_nxt_state;
  logic [7:0]  r_cnt, w_nxt_cnt;
  logic [22:0] r_addr;
  logic [15:0] r_wdata, r_rd_data;
  logic        w_acc, w_drv;
  // all pins decode from state so an asynchronous reset releases the bus at once
  assign cmd_ready = rst_n && r_state == IDLE;
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_drv     = r_state == WR_STB || r_state == WR_REC;
  assign ce_n      = !(r_state == WR_STB || r_state == RD_STB);
  assign we_n      = r_state != WR_STB;
  assign oe_n      = r_state != RD_STB;
  assign wr_done   = r_state == WR_REC;
  assign rd_valid  = r_state == RD_REC;
  assign addr      = r_addr;
  assign rd_data   = r_rd_data;
  assign data      = w_drv ? r_wdata : 16'hzzzz;
`ifdef PCM_RESET_SEQ_EN
  assign pcm_rst_n = r_state != INIT_RST;
`else
  assign pcm_rst_n = 1'b1;
`endif
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt - 8'd1;
    case (r_state)
      INIT_RST: begin
        w_nxt_state = r_cnt == 8'd0 ? INIT_REC : INIT_RST;
        w_nxt_cnt   = r_cnt == 8'd0 ? 8'(REC_CYC - 1) : r_cnt - 8'd1;
      end
      INIT_REC: w_nxt_state = r_cnt == 8'd0 ? IDLE : INIT_REC;
      IDLE: begin
        w_nxt_state = w_acc ? (cmd_we ? WR_STB : RD_STB) : IDLE;
        w_nxt_cnt   = cmd_we ? 8'(WR_CYC - 1) : 8'(RD_CYC - 1);
      end
      WR_STB:  w_nxt_state = r_cnt == 8'd0 ? WR_REC : WR_STB;
      RD_STB:  w_nxt_state = r_cnt == 8'd0 ? RD_REC : RD_STB;
      default: w_nxt_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RST_ST;
      r_cnt     <= RST_CNT;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      if (w_acc) begin
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      if (r_state == RD_STB && r_cnt == 8'd0) r_rd_data <= data;
    end
  end
endmodule

// File: tb/tb_pcm_bus_engine.sv
// tb_pcm_bus_engine: randomized commands checked cycle by cycle against a behavioural PCM model.
// Honours PCM_RESET_SEQ_EN the same way the design does.
module tb_pcm_bus_engine;
  localparam int WR_CYC = 6, RD_CYC = 13, RST_CYC = 16, REC_CYC = 16, RD_LAT = 10;
  logic        clk = 0, rst_n = 0, cmd_valid = 0, cmd_we = 0;
  logic [22:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_ready, rd_valid, wr_done, pcm_rst_n, ce_n, oe_n, we_n;
  logic [15:0] rd_data;
  logic [22:0] addr;
  wire  [15:0] data;
  int          errs = 0, checks = 0, oe_cnt = 0;
  logic [15:0] pcm_mem [256];
  logic [15:0] ref_mem [256];
  logic [15:0] last_rd = '0;
  logic [22:0] last_addr = '0;

  pcm_bus_engine #(.WR_CYC(WR_CYC), .RD_CYC(RD_CYC), .RST_CYC(RST_CYC), .REC_CYC(REC_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_done(wr_done), .addr(addr), .data(data), .pcm_rst_n(pcm_rst_n), .ce_n(ce_n),
    .oe_n(oe_n), .we_n(we_n));

  always #5 clk = ~clk;
  // released bus floats high; the device answers only after RD_LAT cycles of oe_n low
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (data[i]);
  end
  assign data = (!oe_n && !ce_n && oe_cnt >= RD_LAT) ? pcm_mem[addr[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    oe_cnt <= (!oe_n && !ce_n) ? oe_cnt + 1 : 0;
    if (!ce_n && !we_n) pcm_mem[addr[7:0]] <= data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic release_chk();
    int n;
    @(negedge clk);
    rst_n = 1;
    #1;
`ifdef PCM_RESET_SEQ_EN
    n = 0;
    while (!pcm_rst_n && n < 300) begin
      chk("init_rst_pins", {cmd_ready, rd_valid, wr_done}, 3'b000);
      n++;
      @(negedge clk);
    end
    chk("rst_low_len", n, RST_CYC);
    n = 0;
    while (!cmd_ready && n < 300) begin
      chk("init_rec_pins", {pcm_rst_n, rd_valid, wr_done}, 3'b100);
      n++;
      @(negedge clk);
    end
    chk("rec_len", n, REC_CYC);
`else
    chk("norst_pins", {pcm_rst_n, cmd_ready, rd_valid, wr_done}, 4'b1100);
`endif
  endtask

  task automatic do_cmd(input logic we, input logic [22:0] a, input logic [15:0] wd);
    int n = 0;
    int len = we ? WR_CYC : RD_CYC;
    logic [15:0] exp = ref_mem[a[7:0]];
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = wd;
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge clk);
      chk("addr", addr, a);
      if (k <= len) begin
        chk(we ? "wr_stb_ctl" : "rd_stb_ctl", {ce_n, oe_n, we_n, cmd_ready, rd_valid, wr_done},
            we ? 6'b010000 : 6'b001000);
        chk(we ? "wr_stb_data" : "rd_stb_data", data, we ? wd : (k > RD_LAT ? exp : 16'hFFFF));
      end else if (k == len + 1) begin
        chk(we ? "wr_rec_ctl" : "rd_rec_ctl", {ce_n, oe_n, we_n, cmd_ready, rd_valid, wr_done},
            we ? 6'b111001 : 6'b111010);
        chk("rec_data", data, we ? wd : 16'hFFFF);
        chk("rec_rd_data", rd_data, we ? last_rd : exp);
      end else begin
        chk("idle_ctl", {ce_n, oe_n, we_n, cmd_ready, rd_valid, wr_done}, 6'b111100);
        chk("idle_data", data, 16'hFFFF);
        chk("idle_rd_data", rd_data, we ? last_rd : exp);
      end
      cmd_valid = k < len ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_we = 1'($urandom); cmd_addr = 23'($urandom); cmd_wdata = 16'($urandom);
    end
    if (we) ref_mem[a[7:0]] = wd;
    else last_rd = exp;
    last_addr = a;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      pcm_mem[i] = 16'(i) ^ 16'h0089;
      ref_mem[i] = 16'(i) ^ 16'h0089;
    end
    repeat (3) @(negedge clk);
    chk("rst_ctl", {ce_n, oe_n, we_n, cmd_ready, rd_valid, wr_done}, 6'b111000);
    chk("rst_regs", {addr, rd_data}, 39'd0);
    chk("rst_data", data, 16'hFFFF);
`ifdef PCM_RESET_SEQ_EN
    chk("rst_pcm_rst_n", pcm_rst_n, 0);
`else
    chk("rst_pcm_rst_n", pcm_rst_n, 1);
`endif
    release_chk();
    do_cmd(1, 23'h000055, 16'h0090);
    do_cmd(0, 23'h000000, 16'h0000);
    chk("read0_value", rd_data, 16'h0089);
    do_cmd(1, 23'h000012, 16'h1234);
    do_cmd(0, 23'h000012, 16'h0000);
    for (int t = 0; t < 30; t++) begin
      do_cmd(1'($urandom_range(0, 1)), {15'($urandom), 8'($urandom_range(0, 15))},
             16'($urandom_range(0, 16'hFFFE)));
      repeat ($urandom_range(0, 2)) begin
        chk("gap_addr_hold", addr, last_addr);
        chk("gap_ctl", {ce_n, oe_n, we_n, cmd_ready, rd_valid, wr_done}, 6'b111100);
        @(negedge clk);
      end
    end
    cmd_valid = 1; cmd_we = 0; cmd_addr = 23'h000003;
    @(negedge clk);
    cmd_valid = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_ctl", {ce_n, oe_n, we_n, cmd_ready, rd_valid, wr_done}, 6'b111000);
    chk("abort_regs", {addr, rd_data}, 39'd0);
    chk("abort_data", data, 16'hFFFF);
    repeat (2) @(negedge clk);
    last_rd = '0;
    release_chk();
    repeat (3) begin
      chk("abort_no_rd_valid", {rd_valid, wr_done, cmd_ready}, 3'b001);
      @(negedge clk);
    end
    do_cmd(0, 23'h000055, 16'h0000);
    do_cmd(1, 23'h7FFFFF, 16'hBEEF);
    do_cmd(0, 23'h7FFFFF, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
